// File: rtl/vector_mem_responder_if.sv
// Bus bundle for vector_mem_responder.
//   req_*  : processor request channel (valid/ready handshake, scalar or 256-bit vector)
//   rsp_*  : one-cycle completion pulse plus held scalar/vector read results
//   ram_*  : single-port 16-bit registered RAM port (read data one cycle after address)
// Modports:
//   master : the environment (processor + RAM) side
//   slave  : the responder side
interface vector_mem_responder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_vec;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [255:0]      req_wvec;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [255:0]      rsp_rvec;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;

  modport master (
    output req_valid, req_write, req_vec, req_addr, req_wdata, req_wvec, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rvec, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_vec, req_addr, req_wdata, req_wvec, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rvec, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vector_mem_responder.sv
// Vector/scalar memory responder.
// Accepts one request at a time and serialises it into 16-bit beats on a single-port
// registered RAM: 2 beats for a 32-bit scalar, 16 beats for a 256-bit vector. Beat k
// targets halfword (base + k), wrapping modulo 2^ADDR_W.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of vector_mem_responder_if (request, response and RAM port)
// Timing (C0 = acceptance edge):
//   write : C1..CN drive beats, RESP in C(N+1)
//   read  : C1..CN drive addresses, DRAIN in C(N+1), RESP in C(N+2)
module vector_mem_responder #(
  parameter int unsigned ADDR_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  vector_mem_responder_if.slave bus
);

  localparam int unsigned LaneW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        beat_q, beat_d;
  logic              vec_q, vec_d;
  logic              write_q, write_d;
  logic [255:0]      wbuf_q, wbuf_d;
  logic [255:0]      rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [255:0]      rsp_rvec_q, rsp_rvec_d;

  logic [3:0]        beat_nxt;
  logic [3:0]        last_beat;
  logic [3:0]        cap_idx;
  logic [ADDR_W-1:0] req_base;

  // Only the halfword address bits matter; byte bit 0 and upper bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+1], bus.req_addr[0]};

  assign req_base  = bus.req_addr[ADDR_W:1];
  assign beat_nxt  = beat_q + 4'd1;
  assign last_beat = vec_q ? 4'd15 : 4'd1;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    vec_d       = vec_q;
    write_d     = write_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rvec_d  = rsp_rvec_q;
    cap_idx     = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          vec_d      = bus.req_vec;
          wbuf_d     = bus.req_vec ? bus.req_wvec : {224'b0, bus.req_wdata};
          beat_d     = '0;
          ram_addr_d = req_base;
          if (bus.req_write) begin
            // Beat 0 goes out in C1, so it is registered at the acceptance edge.
            ram_we_d    = 1'b1;
            ram_wdata_d = bus.req_vec ? bus.req_wvec[15:0] : bus.req_wdata[15:0];
            state_d     = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end

      StWrite: begin
        if (beat_q == last_beat) begin
          ram_we_d = 1'b0;
          state_d  = StResp;
        end else begin
          beat_d      = beat_nxt;
          ram_addr_d  = ram_addr_q + ADDR_W'(1);
          ram_wdata_d = wbuf_q[LaneW*beat_nxt +: LaneW];
        end
      end

      StRead: begin
        // RAM data for beat k-1 arrives in the cycle that presents beat k's address.
        if (beat_q != 4'd0) begin
          cap_idx                          = beat_q - 4'd1;
          rbuf_d[LaneW*cap_idx +: LaneW]   = bus.ram_rdata;
        end
        if (beat_q == last_beat) begin
          state_d = StDrain;
        end else begin
          beat_d     = beat_nxt;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end

      StDrain: begin
        // Final lane lands now; publish the assembled word straight to the held result.
        cap_idx                        = beat_q;
        rbuf_d[LaneW*cap_idx +: LaneW] = bus.ram_rdata;
        if (vec_q) begin
          rsp_rvec_d = rbuf_d;
        end else begin
          rsp_rdata_d = rbuf_d[31:0];
        end
        state_d = StResp;
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d  = StIdle;
        ram_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      vec_q       <= 1'b0;
      write_q     <= 1'b0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_rvec_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      vec_q       <= vec_d;
      write_q     <= write_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rvec_q  <= rsp_rvec_d;
    end
  end

  // write_q records the request direction; the state encodes it during the transfer.
  logic unused_write;
  assign unused_write = write_q;

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_rvec  = rsp_rvec_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
module tb_vector_mem_responder;

  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vector_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  vector_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered single-port RAM model: read data valid one cycle after the address.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Monitor, sampled on the falling edge while out of reset.
  int cyc = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int acc_cyc[$];
  logic [ADDR_W+15:0] wlog[$];
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (bus.rsp_valid) rsp_cnt++;
      if (bus.ram_we) wlog.push_back({bus.ram_addr, bus.ram_wdata});
    end
  end

  logic [255:0] vec_exp;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Issues one request and returns the cycle index Cn of rsp_valid (-1 on timeout).
  task automatic issue(input logic wr, input logic vec, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [255:0] wvec, output int lat);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.req_write = wr;
    bus.req_vec   = vec;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wvec  = wvec;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 60);
    if (!bus.rsp_valid) lat = -1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0) begin errors++; $display("FAIL rst_ram_addr got %h exp 0", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 16'h0) begin errors++; $display("FAIL rst_ram_wdata got %h exp 0", bus.ram_wdata); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata); end
    checks++; if (bus.rsp_rvec !== 256'h0) begin errors++; $display("FAIL rst_rvec got %h exp 0", bus.rsp_rvec); end
    reset = 1'b1;
  endtask

  task automatic test_scalar();
    int lat;
    int ws;
    ws = wlog.size();
    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 256'h0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sc_wr_lat got %0d exp 3", lat); end
    checks++; if (wlog.size() - ws !== 2) begin errors++; $display("FAIL sc_wr_beats got %0d exp 2", wlog.size() - ws); end
    if (wlog.size() - ws >= 2) begin
      checks++; if (wlog[ws] !== 32'h0008_BEEF) begin errors++; $display("FAIL sc_wr_beat0 got %h exp 0008beef", wlog[ws]); end
      checks++; if (wlog[ws+1] !== 32'h0009_DEAD) begin errors++; $display("FAIL sc_wr_beat1 got %h exp 0009dead", wlog[ws+1]); end
    end
    @(negedge clk);
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL sc_idle_we got %b exp 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h9) begin errors++; $display("FAIL sc_idle_addr got %h exp 0009", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 16'hDEAD) begin errors++; $display("FAIL sc_idle_wdata got %h exp dead", bus.ram_wdata); end
    issue(1'b0, 1'b0, 32'h10, 32'h0, 256'h0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sc_rd_lat got %0d exp 4", lat); end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_rd_data got %h exp deadbeef", bus.rsp_rdata); end
    checks++; if (bus.rsp_rvec !== 256'h0) begin errors++; $display("FAIL sc_rd_rvec got %h exp 0", bus.rsp_rvec); end
  endtask

  task automatic test_vector();
    int lat;
    int ws;
    int bad;
    for (int k = 0; k < 16; k++) vec_exp[16*k +: 16] = 16'h1000 + 16'(k);
    ws = wlog.size();
    issue(1'b1, 1'b1, 32'h40, 32'h0, vec_exp, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL vec_wr_lat got %0d exp 17", lat); end
    checks++; if (wlog.size() - ws !== 16) begin errors++; $display("FAIL vec_wr_beats got %0d exp 16", wlog.size() - ws); end
    bad = 0;
    for (int k = 0; k < 16 && ws + k < wlog.size(); k++)
      if (wlog[ws+k] !== {16'h0020 + 16'(k), 16'h1000 + 16'(k)}) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL vec_wr_order got %0d bad beats exp 0", bad); end
    issue(1'b0, 1'b1, 32'h40, 32'h0, 256'h0, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL vec_rd_lat got %0d exp 18", lat); end
    checks++; if (bus.rsp_rvec !== vec_exp) begin errors++; $display("FAIL vec_rd_data got %h exp %h", bus.rsp_rvec, vec_exp); end
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL vec_rd_rdata_kept got %h exp deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_result_hold();
    int lat;
    logic [255:0] v;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 256'h0, lat);
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rd got %h exp deadbeef", bus.rsp_rdata); end
    for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'h7000 + 16'(k);
    issue(1'b1, 1'b1, 32'h80, 32'h0, v, lat);
    checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rdata got %h exp deadbeef", bus.rsp_rdata); end
    checks++; if (bus.rsp_rvec !== vec_exp) begin errors++; $display("FAIL hold_rvec got %h exp %h", bus.rsp_rvec, vec_exp); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [255:0] v;
    logic [15:0] a;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'h2000 + 16'(k);
    issue(1'b1, 1'b1, 32'h0001_FFF8, 32'h0, v, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL wrap_wr_lat got %0d exp 17", lat); end
    for (int k = 0; k < 16; k++) begin
      a = 16'hFFFC + 16'(k);
      checks++;
      if (mem[a] !== 16'h2000 + 16'(k)) begin
        errors++; $display("FAIL wrap_mem[%h] got %h exp %h", a, mem[a], 16'h2000 + 16'(k));
      end
    end
    issue(1'b0, 1'b1, 32'h0001_FFF8, 32'h0, 256'h0, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL wrap_rd_lat got %0d exp 18", lat); end
    checks++; if (bus.rsp_rvec !== v) begin errors++; $display("FAIL wrap_rd_data got %h exp %h", bus.rsp_rvec, v); end
  endtask

  task automatic test_back_to_back();
    int acc0;
    int rsp0;
    int ws;
    int lat;
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    ws = wlog.size();
    @(posedge clk); #1;
    bus.req_write = 1'b1;
    bus.req_vec   = 1'b0;
    bus.req_addr  = 32'h200;
    bus.req_wdata = 32'h1111_2222;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    // Valid stays high through WRITE/WRITE/RESP while the fields change.
    for (int i = 1; i <= 3; i++) begin
      bus.req_write = 1'b1;
      bus.req_vec   = 1'b1;
      bus.req_addr  = 32'h600 + 32'(i);
      bus.req_wdata = 32'hBAD0_0000 + 32'(i);
      bus.req_wvec  = {16{16'hBAD0 + 16'(i)}};
      @(posedge clk); #1;
    end
    bus.req_vec   = 1'b0;
    bus.req_addr  = 32'h300;
    bus.req_wdata = 32'h3333_4444;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 60);
    #1;
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_second_lat got %0d exp 3", lat); end
    checks++; if (acc_cnt - acc0 !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_cnt - acc0); end
    if (acc_cnt - acc0 >= 2) begin
      checks++;
      if (acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2] !== 4) begin
        errors++; $display("FAIL b2b_period got %0d exp 4", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]);
      end
    end
    checks++; if (rsp_cnt - rsp0 !== 2) begin errors++; $display("FAIL b2b_rsps got %0d exp 2", rsp_cnt - rsp0); end
    checks++; if (wlog.size() - ws !== 4) begin errors++; $display("FAIL b2b_beats got %0d exp 4", wlog.size() - ws); end
    if (wlog.size() - ws >= 4) begin
      checks++; if (wlog[ws] !== 32'h0100_2222) begin errors++; $display("FAIL b2b_beat0 got %h exp 01002222", wlog[ws]); end
      checks++; if (wlog[ws+1] !== 32'h0101_1111) begin errors++; $display("FAIL b2b_beat1 got %h exp 01011111", wlog[ws+1]); end
      checks++; if (wlog[ws+2] !== 32'h0180_4444) begin errors++; $display("FAIL b2b_beat2 got %h exp 01804444", wlog[ws+2]); end
      checks++; if (wlog[ws+3] !== 32'h0181_3333) begin errors++; $display("FAIL b2b_beat3 got %h exp 01813333", wlog[ws+3]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int rsp0;
    logic [255:0] v;
    logic [15:0] e;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'hA000 + 16'(k);
    issue(1'b1, 1'b1, 32'h800, 32'h0, v, lat);
    for (int k = 0; k < 16; k++) v[16*k +: 16] = 16'h5000 + 16'(k);
    rsp0 = rsp_cnt;
    @(posedge clk); #1;
    bus.req_write = 1'b1;
    bus.req_vec   = 1'b1;
    bus.req_addr  = 32'h800;
    bus.req_wvec  = v;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // Now in C1; after six more edges beats 0..5 are in RAM and beat 6 is on the bus.
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL mid_we_before got %b exp 1", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0406) begin errors++; $display("FAIL mid_addr_before got %h exp 0406", bus.ram_addr); end
    reset = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL mid_we_async got %b exp 0", bus.ram_we); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata_clr got %h exp 0", bus.rsp_rdata); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    checks++; if (rsp_cnt - rsp0 !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d exp 0", rsp_cnt - rsp0); end
    for (int k = 0; k < 16; k++) begin
      e = (k <= 5) ? 16'h5000 + 16'(k) : 16'hA000 + 16'(k);
      checks++;
      if (mem[16'h0400 + 16'(k)] !== e) begin
        errors++; $display("FAIL mid_mem[%0d] got %h exp %h", k, mem[16'h0400 + 16'(k)], e);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wvec  = '0;
    vec_exp       = '0;
    test_reset();
    test_scalar();
    test_vector();
    test_result_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_responder.md
VECTOR_MEM_RESPONDER -- requirements
Module: vector_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, width in bits of the 16-bit-halfword RAM address.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 req_valid  input  1  processor presents a memory request.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_vec  input  1  1 = 256-bit vector access, 0 = 32-bit scalar access.
REQ-008 req_addr  input  32  byte address; halfword base = req_addr[ADDR_W:1], bit 0 ignored.
REQ-009 req_wdata  input  32  scalar write data.
REQ-010 req_wvec  input  256  vector write data, 16 lanes of 16 bits.
REQ-011 rsp_valid  output  1  one-cycle completion pulse for every accepted request.
REQ-012 rsp_rdata  output  32  scalar read result.
REQ-013 rsp_rvec  output  256  vector read result.
REQ-014 ram_addr  output  ADDR_W  halfword address to the single-port 16-bit RAM.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_wdata  output  16  RAM write data.
REQ-017 ram_rdata  input  16  RAM read data; valid one cycle after ram_addr is presented (registered RAM).

Function
REQ-018 Request accepted on the rising edge where req_valid & req_ready; all req_* fields are captured in registers at that edge.
REQ-019 req_ready = 1 only in state IDLE; req_* ignored in all other states.
REQ-020 States: IDLE, WRITE, READ, DRAIN, RESP.
REQ-021 Beat count N = 16 for vector, 2 for scalar; beat k targets halfword (base + k) mod 2^ADDR_W.
REQ-022 Lane order: beat k carries bits [16k+15:16k]; scalar beat 0 = bits [15:0], beat 1 = bits [31:16].
REQ-023 Write: IDLE -> WRITE on acceptance; cycles C1..CN drive ram_we=1, ram_addr=base+k-1, ram_wdata=beat k-1; then RESP in C(N+1); then IDLE in C(N+2).
REQ-024 Read: IDLE -> READ on acceptance; cycles C1..CN drive ram_addr=base+k-1 with ram_we=0; DRAIN in C(N+1); RESP in C(N+2); then IDLE.
REQ-025 Read capture: ram_rdata sampled into lane k on the edge ending the cycle after beat k's address; all N lanes are captured before RESP.
REQ-026 rsp_valid = 1 exactly in RESP, one cycle per request, for both reads and writes.
REQ-027 On read RESP, the result is stable: rsp_rdata (scalar) or rsp_rvec (vector) holds the assembled data; the other result output is unchanged.
REQ-028 rsp_rdata and rsp_rvec hold their value until the next read of the same kind completes; writes never modify them.
REQ-029 ram_we = 0 in all states except WRITE; ram_addr and ram_wdata hold their last value when idle.
REQ-030 Address wrap: halfword 2^ADDR_W-1 is followed by halfword 0 with no error indication.
REQ-031 A new request may be accepted in the IDLE cycle immediately after RESP; back-to-back throughput is N+2 cycles per write and N+3 cycles per read.

Reset
REQ-032 When reset is 0: state = IDLE, req_ready = 1, rsp_valid = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rsp_rdata = 0, rsp_rvec = 0, all internal counters and buffers = 0.
REQ-033 Reset asserted mid-operation aborts the transfer: ram_we falls asynchronously and no rsp_valid is produced for the aborted request; beats already written remain in RAM.

Verification
REQ-034 Scalar write then read: write 0xDEADBEEF to byte address 0x10 -> ram_we 2 cycles at halfwords 8, 9 with data 0xBEEF, 0xDEAD; rsp_valid in C3; the following read returns rsp_rdata = 0xDEADBEEF with rsp_valid in C4.
REQ-035 Vector round trip: write lanes k = 0x1000+k at byte address 0x40 -> 16 beats at halfwords 0x20..0x2F; a vector read of the same address asserts rsp_valid in C18 with rsp_rvec lane k = 0x1000+k.
REQ-036 Wrap-around: vector write at halfword 2^ADDR_W-4 -> beats 4..15 land at halfwords 0..11; readback matches.
REQ-037 Handshake: req_valid held high during a transfer with changing req_* fields -> no second acceptance until IDLE; the captured request is unchanged; exactly one rsp_valid per acceptance.
REQ-038 Reset mid-vector-write after beat 5 -> ram_we = 0 immediately, req_ready = 1, no rsp_valid; halfwords base..base+5 hold new data and the rest hold old data.
REQ-039 Result holding: a scalar read is followed by a vector write -> rsp_rdata and rsp_rvec are unchanged across the write.
